reset_sequencer: RTL and testbench

//  System reset controller sitting between the FPGA start/PLL status and every GM64 core block.

---
 rtl/reset_sequencer_pkg.sv | 24 ++
 rtl/reset_sequencer_if.sv | 25 ++
 rtl/reset_sequencer_button_debounce.sv | 43 ++++
 rtl/reset_sequencer.sv | 130 +++++++++++++
 tb/tb_reset_sequencer.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/reset_sequencer_pkg.sv
// Shared types and default timing for the GM64 reset sequencer.
package gm64_reset_pkg;

    typedef enum logic [1:0] {
        S_WAIT,
        S_HOLD,
        S_REL,
        S_RUN
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'b00,
        CAUSE_POWER  = 2'b01,
        CAUSE_BUTTON = 2'b10,
        CAUSE_PLL    = 2'b11
    } cause_e;

    // Defaults assume a 10 MHz system clock.
    localparam int HOLD_CYCLES_DEF     = 500_000;
    localparam int DEBOUNCE_CYCLES_DEF = 100_000;
    localparam int STAGE_GAP_DEF       = 16;
    localparam int NUM_STAGES_DEF      = 3;

endpackage

// File: rtl/reset_sequencer_if.sv
// Board-side status inputs and per-domain reset/status outputs of the sequencer.
interface reset_sequencer_if #(
    parameter int NUM_STAGES = 3
);
    import gm64_reset_pkg::*;

    logic                  fpga_start;
    logic                  pll_locked;
    logic                  fpga_but1;
    logic [NUM_STAGES-1:0] sys_reset;
    logic                  led;
    logic                  busy;
    cause_e                cause;

    modport master (
        input  fpga_start, pll_locked, fpga_but1,
        output sys_reset, led, busy, cause
    );

    modport slave (
        output fpga_start, pll_locked, fpga_but1,
        input  sys_reset, led, busy, cause
    );

endinterface

// File: rtl/reset_sequencer_button_debounce.sv
// Active-low button: 2-FF sync, stability counter, one-cycle press pulse on debounced 1->0.
module button_debounce
    import gm64_reset_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic button,
    output logic pressed,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;

    // Sync chain resets to "released" so leaving reset never fakes a press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync  <= 2'b11;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], button};
            press <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync[1];
                cnt   <= '0;
                press <= level;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign pressed = ~level;

endmodule

// File: rtl/reset_sequencer.sv
// System reset controller: holds all domains in reset after an event, then releases them in order.
module reset_sequencer
    import gm64_reset_pkg::*;
#(
    parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int STAGE_GAP       = STAGE_GAP_DEF,
    parameter int NUM_STAGES      = NUM_STAGES_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    reset_sequencer_if.master bus
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int GW = $clog2(STAGE_GAP + 1);
    localparam logic [NUM_STAGES-1:0] ALL_ON = '1;

    logic [1:0]            pll_sync;
    logic                  pll_ok;
    logic                  pressed;
    logic                  press;
    state_e                state, state_nxt;
    cause_e                cause, cause_nxt;
    logic [HW-1:0]         hold_cnt, hold_nxt;
    logic [GW-1:0]         gap_cnt, gap_nxt;
    logic [NUM_STAGES-1:0] sys_reset, sys_nxt;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .button  (bus.fpga_but1),
        .pressed (pressed),
        .press   (press)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pll_sync <= 2'b00;
        else          pll_sync <= {pll_sync[0], bus.pll_locked};
    end
    assign pll_ok = pll_sync[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_WAIT;
            cause     <= CAUSE_NONE;
            hold_cnt  <= '0;
            gap_cnt   <= '0;
            sys_reset <= ALL_ON;
        end else begin
            state     <= state_nxt;
            cause     <= cause_nxt;
            hold_cnt  <= hold_nxt;
            gap_cnt   <= gap_nxt;
            sys_reset <= sys_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cause_nxt = cause;
        hold_nxt  = hold_cnt;
        gap_nxt   = gap_cnt;
        sys_nxt   = sys_reset;

        // Stages release by shifting zeros in from bit 0, so order is fixed by construction.
        case (state)
            S_WAIT: begin
                sys_nxt  = ALL_ON;
                hold_nxt = '0;
                gap_nxt  = '0;
                if (bus.fpga_start && pll_ok) begin
                    state_nxt = S_HOLD;
                    if (cause != CAUSE_PLL) cause_nxt = CAUSE_POWER;
                end
            end
            S_HOLD: begin
                sys_nxt = ALL_ON;
                if (pressed) begin
                    hold_nxt = '0;
                end else if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                    hold_nxt  = '0;
                    gap_nxt   = '0;
                    sys_nxt   = ALL_ON << 1;
                    state_nxt = (sys_nxt == '0) ? S_RUN : S_REL;
                end else begin
                    hold_nxt = hold_cnt + HW'(1);
                end
            end
            S_REL: begin
                if (gap_cnt == GW'(STAGE_GAP - 1)) begin
                    gap_nxt = '0;
                    sys_nxt = sys_reset << 1;
                    if (sys_nxt == '0) state_nxt = S_RUN;
                end else begin
                    gap_nxt = gap_cnt + GW'(1);
                end
            end
            S_RUN:   sys_nxt = '0;
            default: state_nxt = S_WAIT;
        endcase

        if (!pll_ok && state != S_WAIT) begin
            state_nxt = S_WAIT;
            cause_nxt = CAUSE_PLL;
            sys_nxt   = ALL_ON;
            hold_nxt  = '0;
            gap_nxt   = '0;
        end else if (!bus.fpga_start && state != S_WAIT) begin
            state_nxt = S_WAIT;
            sys_nxt   = ALL_ON;
            hold_nxt  = '0;
            gap_nxt   = '0;
        end else if (press && (state == S_REL || state == S_RUN)) begin
            state_nxt = S_HOLD;
            cause_nxt = CAUSE_BUTTON;
            sys_nxt   = ALL_ON;
            hold_nxt  = '0;
            gap_nxt   = '0;
        end else if (press && state == S_HOLD) begin
            cause_nxt = CAUSE_BUTTON;
            hold_nxt  = '0;
        end
    end

    assign bus.sys_reset = sys_reset;
    assign bus.led       = |sys_reset;
    assign bus.busy      = (state != S_RUN);
    assign bus.cause     = cause;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench: power-on, bounce, press, held button, fpga_start drop, PLL loss, async reset.
module tb_reset_sequencer;
    import gm64_reset_pkg::*;

    logic clk;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    reset_sequencer_if #(.NUM_STAGES(3)) bus ();

    reset_sequencer #(
        .HOLD_CYCLES     (20),
        .DEBOUNCE_CYCLES (4),
        .STAGE_GAP       (3),
        .NUM_STAGES      (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        bus.fpga_start = 1'b1;
        bus.pll_locked = 1'b1;
        bus.fpga_but1  = 1'b1;
        ticks(3);
        chk("rst_sys",   bus.sys_reset, 3'b111);
        chk("rst_led",   bus.led,       1);
        chk("rst_busy",  bus.busy,      1);
        chk("rst_cause", bus.cause,     2'b00);

        // Power-on: 2 edges of PLL sync, third edge enters hold.
        reset_n = 1'b1;
        ticks(3);
        ticks(19); chk("por_hold19", bus.sys_reset, 3'b111);
        tick();    chk("por_s0",     bus.sys_reset, 3'b110);
        ticks(2);  chk("por_gap",    bus.sys_reset, 3'b110);
        tick();    chk("por_s1",     bus.sys_reset, 3'b100);
        ticks(3);  chk("por_s2",     bus.sys_reset, 3'b000);
        chk("por_led",   bus.led,   0);
        chk("por_busy",  bus.busy,  0);
        chk("por_cause", bus.cause, 2'b01);

        // Short bounce: 3 low cycles never reach the debounce threshold.
        bus.fpga_but1 = 1'b0; ticks(3);
        bus.fpga_but1 = 1'b1; ticks(10);
        chk("bounce_sys",   bus.sys_reset, 3'b000);
        chk("bounce_cause", bus.cause,     2'b01);

        // Real press: debounced at edge 6, reset at edge 7; release debounced at edge 12.
        bus.fpga_but1 = 1'b0; ticks(6);
        chk("press_pre", bus.sys_reset, 3'b000);
        bus.fpga_but1 = 1'b1; tick();
        chk("press_sys",   bus.sys_reset, 3'b111);
        chk("press_cause", bus.cause,     2'b10);
        chk("press_busy",  bus.busy,      1);
        ticks(24); chk("press_hold", bus.sys_reset, 3'b111);
        tick();    chk("press_s0",   bus.sys_reset, 3'b110);
        ticks(3);  chk("press_s1",   bus.sys_reset, 3'b100);
        ticks(3);  chk("press_s2",   bus.sys_reset, 3'b000);
        chk("press_run_busy", bus.busy, 0);

        // Held button: 100 cycles low, hold counter frozen, release 20 after debounced release.
        bus.fpga_but1 = 1'b0;
        ticks(7);  chk("held_press", bus.sys_reset, 3'b111);
        ticks(43); chk("held_mid",   bus.sys_reset, 3'b111);
        ticks(50); chk("held_end",   bus.sys_reset, 3'b111);
        chk("held_cause", bus.cause, 2'b10);
        bus.fpga_but1 = 1'b1;
        ticks(25); chk("held_hold", bus.sys_reset, 3'b111);
        tick();    chk("held_s0",   bus.sys_reset, 3'b110);
        ticks(6);  chk("held_s2",   bus.sys_reset, 3'b000);

        // fpga_start drop in run: immediate reset, cause kept; re-entry sets power cause.
        bus.fpga_start = 1'b0; tick();
        chk("fs_sys",   bus.sys_reset, 3'b111);
        chk("fs_busy",  bus.busy,      1);
        chk("fs_cause", bus.cause,     2'b10);
        bus.fpga_start = 1'b1; tick();
        chk("fs_cause_por", bus.cause, 2'b01);
        ticks(20); chk("fs_s0", bus.sys_reset, 3'b110);

        // PLL loss after stage 0 release: seen through 2-FF sync, wins over stage 1 release.
        bus.pll_locked = 1'b0;
        ticks(2); chk("pll_pre",   bus.sys_reset, 3'b110);
        tick();   chk("pll_sys",   bus.sys_reset, 3'b111);
        chk("pll_cause", bus.cause, 2'b11);
        chk("pll_busy",  bus.busy,  1);
        ticks(5); chk("pll_wait",  bus.sys_reset, 3'b111);
        bus.pll_locked = 1'b1;
        ticks(3);
        ticks(19); chk("pll_hold", bus.sys_reset, 3'b111);
        tick();    chk("pll_s0",   bus.sys_reset, 3'b110);
        ticks(3);  chk("pll_s1",   bus.sys_reset, 3'b100);
        ticks(3);  chk("pll_s2",   bus.sys_reset, 3'b000);
        chk("pll_cause_kept", bus.cause, 2'b11);
        chk("pll_run_busy",   bus.busy,  0);

        // reset_n pulse mid-release takes effect between clock edges.
        bus.fpga_start = 1'b0; tick();
        bus.fpga_start = 1'b1; tick();
        ticks(21); chk("rel_mid", bus.sys_reset, 3'b110);
        #2 reset_n = 1'b0;
        #1;
        chk("async_sys",   bus.sys_reset, 3'b111);
        chk("async_led",   bus.led,       1);
        chk("async_busy",  bus.busy,      1);
        chk("async_cause", bus.cause,     2'b00);
        ticks(2);
        reset_n = 1'b1;
        ticks(3);
        ticks(20); chk("post_rst_s0",    bus.sys_reset, 3'b110);
        chk("post_rst_cause", bus.cause, 2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
